// File: rtl/ss_pkg.sv
// Shared definitions for the store-size unit: size codes, FSM state type and
// the alignment/legality check used when a store is accepted.
package ss_pkg;

   localparam logic [1:0] SS_SW  = 2'b00;
   localparam logic [1:0] SS_SH  = 2'b01;
   localparam logic [1:0] SS_SB  = 2'b10;
   localparam logic [1:0] SS_ILL = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_READ  = 3'd1,
      ST_WRITE = 3'd2,
      ST_DONE  = 3'd3,
      ST_ERR   = 3'd4
   } ss_state_t;

   // True when the size code is illegal or the byte offset does not suit the size.
   function automatic logic ss_bad(input logic [1:0] size, input logic [1:0] lane);
      logic bad;
      bad = 1'b0;
      case (size)
         SS_SW:   bad = (lane != 2'b00);
         SS_SH:   bad = lane[0];
         SS_SB:   bad = 1'b0;
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/ss_merge.sv
// Lane merge: overlays the halfword or byte of store data onto the memory word.
module ss_merge
   import ss_pkg::*;
(
   input  logic [31:0] word,
   input  logic [31:0] data,
   input  logic [1:0]  size,
   input  logic [1:0]  lane,
   output logic [31:0] merged
);

   // Start from the memory word and replace only the addressed lane.
   always_comb begin
      merged = word;
      case (size)
         SS_SW: merged = data;
         SS_SH: begin
            if (lane[1]) merged[31:16] = data[15:0];
            else         merged[15:0]  = data[15:0];
         end
         SS_SB: merged[{lane, 3'b000} +: 8] = data[7:0];
         default: merged = word;
      endcase
   end

endmodule

// File: rtl/store_size_unit.sv
// Store-size stage: sw passes regB through, sh/sb read-modify-write the aligned
// memory word and present the merged word with a single-cycle write strobe.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | waiting for start; inputs latched when start is accepted
//   ST_READ  | memory read in flight, MEM_LAT cycles, counter runs down
//   ST_WRITE | memWrite high for one cycle, SSout/memAddr stable
//   ST_DONE  | done pulse
//   ST_ERR   | done + err pulse, no write issued
module store_size_unit
   import ss_pkg::*;
#(
   parameter int MEM_LAT = 1
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [1:0]  SSControl,
   input  logic [31:0] addr,
   input  logic [31:0] regB,
   input  logic [31:0] memData,
   output logic [31:0] memAddr,
   output logic        memWrite,
   output logic [31:0] SSout,
   output logic        busy,
   output logic        done,
   output logic        err
);

   localparam int CW = $clog2(MEM_LAT + 1);
   localparam logic [CW-1:0] CNT_LOAD = CW'(MEM_LAT - 1);

   ss_state_t   state, state_nxt;
   logic [CW-1:0] cnt;
   logic [1:0]  size_q;
   logic [1:0]  lane_q;
   logic [31:0] regb_q;
   logic [31:0] merged;
   logic        accept;
   logic        read_last;

   assign accept    = (state == ST_IDLE) && start;
   assign read_last = (state == ST_READ) && (cnt == '0);

   ss_merge u_merge (
      .word   (memData),
      .data   (regb_q),
      .size   (size_q),
      .lane   (lane_q),
      .merged (merged)
   );

   // State register; async reset forces IDLE so all strobes drop at once.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   // Next-state decode.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (start) begin
               if (ss_bad(SSControl, addr[1:0])) state_nxt = ST_ERR;
               else if (SSControl == SS_SW)      state_nxt = ST_WRITE;
               else                              state_nxt = ST_READ;
            end
         end
         ST_READ:  if (cnt == '0) state_nxt = ST_WRITE;
         ST_WRITE: state_nxt = ST_DONE;
         ST_DONE:  state_nxt = ST_IDLE;
         ST_ERR:   state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // Strobes decoded purely from the registered state.
   always_comb begin
      busy     = (state != ST_IDLE);
      memWrite = (state == ST_WRITE);
      done     = (state == ST_DONE) || (state == ST_ERR);
      err      = (state == ST_ERR);
   end

   // Latch the request on acceptance; inputs are ignored for the rest of the op.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         size_q  <= SS_SW;
         lane_q  <= 2'b00;
         regb_q  <= '0;
         memAddr <= '0;
      end else if (accept) begin
         size_q  <= SSControl;
         lane_q  <= addr[1:0];
         regb_q  <= regB;
         memAddr <= {addr[31:2], 2'b00};
      end
   end

   // Read-latency down-counter; terminal count ends the READ phase.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                  cnt <= '0;
      else if (accept)            cnt <= CNT_LOAD;
      else if (state == ST_READ && cnt != '0) cnt <= cnt - 1'b1;
   end

   // SSout loads from regB for a legal sw, or from the merge on the last read
   // cycle; otherwise it holds so the consumer sees a steady value.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         SSout <= '0;
      end else if (accept && SSControl == SS_SW && !ss_bad(SSControl, addr[1:0])) begin
         SSout <= regB;
      end else if (read_last) begin
         SSout <= merged;
      end
   end

endmodule

// File: tb/tb_store_size_unit.sv
// Self-checking bench for store_size_unit with a three-cycle read latency.
module tb_store_size_unit;

   localparam int LAT = 3;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [1:0]  SSControl;
   logic [31:0] addr;
   logic [31:0] regB;
   logic [31:0] memData;
   logic [31:0] memAddr;
   logic        memWrite;
   logic [31:0] SSout;
   logic        busy;
   logic        done;
   logic        err;

   int n_tests = 0;
   int n_fail  = 0;

   store_size_unit #(.MEM_LAT(LAT)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .SSControl (SSControl),
      .addr      (addr),
      .regB      (regB),
      .memData   (memData),
      .memAddr   (memAddr),
      .memWrite  (memWrite),
      .SSout     (SSout),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  ctl;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] md;
      logic [31:0] exp_ss;
      logic [31:0] exp_ma;
      logic        exp_err;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Reference model: legality and merged word from plain arithmetic.
   function automatic logic model_err(input logic [1:0] ctl, input logic [31:0] a);
      if (ctl == 2'd3) return 1'b1;
      if (ctl == 2'd0) return (a % 4) != 0;
      if (ctl == 2'd1) return (a % 2) != 0;
      return 1'b0;
   endfunction

   function automatic logic [31:0] model_ss(input logic [1:0] ctl, input logic [31:0] a,
                                            input logic [31:0] b, input logic [31:0] md);
      int sh;
      logic [31:0] mask;
      if (ctl == 2'd0) return b;
      if (ctl == 2'd2) begin
         sh   = 8 * int'(a % 4);
         mask = 32'h0000_00FF << sh;
         return (md & ~mask) | ((b & 32'h0000_00FF) << sh);
      end
      sh   = 16 * int'((a % 4) / 2);
      mask = 32'h0000_FFFF << sh;
      return (md & ~mask) | ((b & 32'h0000_FFFF) << sh);
   endfunction

   // Issue one store and watch it to completion. Cycle 1 is the cycle after the
   // accepting edge. Outputs are sampled on the falling edge.
   task automatic run_op(input logic [1:0] ctl, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] md,
                         output int wr_cyc, output int done_cyc, output int n_wr,
                         output logic err_seen, output logic [31:0] ss_wr,
                         output logic [31:0] ma_wr);
      int cyc;
      wr_cyc = -1; done_cyc = -1; n_wr = 0; err_seen = 1'b0;
      ss_wr = 'x; ma_wr = 'x;
      SSControl = ctl; addr = a; regB = b; memData = md; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      cyc = 0;
      while (done_cyc < 0 && cyc < 20) begin
         @(negedge clk);
         cyc++;
         if (memWrite) begin
            n_wr++;
            wr_cyc = cyc;
            ss_wr  = SSout;
            ma_wr  = memAddr;
         end
         if (done) begin
            done_cyc = cyc;
            err_seen = err;
         end
      end
      if (done_cyc < 0) check("op_timeout", 32'(cyc), 32'hFFFF_FFFF);
      @(posedge clk); #1;
   endtask

   task automatic apply(input string tag, input logic [1:0] ctl, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] md,
                        input logic [31:0] exp_ss, input logic [31:0] exp_ma,
                        input logic exp_err);
      int wc, dc, nw;
      logic es;
      logic [31:0] ss, ma;
      run_op(ctl, a, b, md, wc, dc, nw, es, ss, ma);
      check({tag, "_err"}, 32'(es), 32'(exp_err));
      if (exp_err) begin
         check({tag, "_done_cyc"}, 32'(dc), 32'd1);
         check({tag, "_nwrites"}, 32'(nw), 32'd0);
      end else begin
         check({tag, "_nwrites"}, 32'(nw), 32'd1);
         check({tag, "_wr_cyc"}, 32'(wc), (ctl == 2'd0) ? 32'd1 : 32'(LAT + 1));
         check({tag, "_done_cyc"}, 32'(dc), 32'(wc + 1));
         check({tag, "_ssout"}, ss, exp_ss);
         check({tag, "_memaddr"}, ma, exp_ma);
      end
   endtask

   initial begin
      int nw;
      logic [31:0] held;
      start = 0; SSControl = 0; addr = 0; regB = 0; memData = 0;
      reset = 1'b1;
      #12;
      check("rst_memwrite", 32'(memWrite), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_ssout", SSout, 32'd0);
      check("rst_memaddr", memAddr, 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;

      vecs.push_back('{2'd0, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,         32'hDEAD_BEEF, 32'h10, 1'b0});
      vecs.push_back('{2'd2, 32'h0000_0040, 32'h0000_00AB, 32'h1122_3344, 32'h1122_33AB, 32'h40, 1'b0});
      vecs.push_back('{2'd2, 32'h0000_0041, 32'h0000_00AB, 32'h1122_3344, 32'h1122_AB44, 32'h40, 1'b0});
      vecs.push_back('{2'd2, 32'h0000_0042, 32'h0000_00AB, 32'h1122_3344, 32'h11AB_3344, 32'h40, 1'b0});
      vecs.push_back('{2'd2, 32'h0000_0043, 32'h0000_00AB, 32'h1122_3344, 32'hAB22_3344, 32'h40, 1'b0});
      vecs.push_back('{2'd1, 32'h0000_0022, 32'h0000_CAFE, 32'h1122_3344, 32'hCAFE_3344, 32'h20, 1'b0});
      vecs.push_back('{2'd1, 32'h0000_0020, 32'h5555_CAFE, 32'h1122_3344, 32'h1122_CAFE, 32'h20, 1'b0});
      vecs.push_back('{2'd2, 32'hFFFF_FFF3, 32'h1234_56CD, 32'hFFFF_0000, 32'hCDFF_0000, 32'hFFFF_FFF0, 1'b0});
      vecs.push_back('{2'd1, 32'h0000_0021, 32'h0000_CAFE, 32'h1122_3344, 32'h0,         32'h0, 1'b1});
      vecs.push_back('{2'd1, 32'h0000_0023, 32'h0000_CAFE, 32'h1122_3344, 32'h0,         32'h0, 1'b1});
      vecs.push_back('{2'd0, 32'h0000_0013, 32'h0000_0001, 32'h0,         32'h0,         32'h0, 1'b1});
      vecs.push_back('{2'd3, 32'h0000_0000, 32'h0000_0001, 32'h0,         32'h0,         32'h0, 1'b1});

      foreach (vecs[i])
         apply($sformatf("vec%0d", i), vecs[i].ctl, vecs[i].a, vecs[i].b, vecs[i].md,
               vecs[i].exp_ss, vecs[i].exp_ma, vecs[i].exp_err);

      // Randomized stores against the arithmetic model.
      for (int i = 0; i < 40; i++) begin
         logic [1:0]  c;
         logic [31:0] a, b, m;
         c = 2'($urandom_range(0, 3));
         a = $urandom; b = $urandom; m = $urandom;
         apply($sformatf("rnd%0d", i), c, a, b, m, model_ss(c, a, b, m),
               {a[31:2], 2'b00}, model_err(c, a));
      end

      // SSout holds after done.
      held = SSout;
      repeat (3) @(posedge clk);
      #1 check("ssout_hold", SSout, held);

      // Second start during READ is ignored; exactly one write results.
      SSControl = 2'd2; addr = 32'h100; regB = 32'h11; memData = 32'hAAAA_AAAA; start = 1;
      @(posedge clk); #1;
      start = 0;
      @(posedge clk); #1;
      SSControl = 2'd0; addr = 32'h200; regB = 32'h22; start = 1;
      @(posedge clk); #1;
      start = 0;
      nw = 0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (memWrite) begin
            nw++;
            check("busy_ss", SSout, 32'hAAAA_AA11);
            check("busy_ma", memAddr, 32'h100);
         end
      end
      check("busy_nwrites", 32'(nw), 32'd1);

      // start held through WRITE and DONE of a sw is taken only once.
      SSControl = 2'd0; addr = 32'h300; regB = 32'h3333_3333; start = 1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      start = 0;
      check("b2b_idle", 32'(busy), 32'd0);
      nw = 0;
      repeat (4) begin
         @(negedge clk);
         if (memWrite) nw++;
      end
      check("b2b_extra_write", 32'(nw), 32'd0);

      // Reset in the middle of READ.
      SSControl = 2'd1; addr = 32'h400; regB = 32'h4444; memData = 32'h0; start = 1;
      @(posedge clk); #1;
      start = 0;
      @(negedge clk);
      check("midrst_busy_before", 32'(busy), 32'd1);
      reset = 1'b1;
      #1;
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_memwrite", 32'(memWrite), 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      nw = 0;
      repeat (10) begin
         @(negedge clk);
         if (memWrite || busy) nw++;
      end
      check("midrst_no_activity", 32'(nw), 32'd0);

      // Input changes after acceptance do not affect the running store.
      begin
         int wc;
         logic [31:0] ss;
         wc = -1; ss = '0;
         SSControl = 2'd2; addr = 32'h0000_0081; regB = 32'h0000_0077;
         memData = 32'h1020_3040; start = 1;
         @(posedge clk); #1;
         start = 0;
         regB = 32'h0000_00FF; addr = 32'h0000_0F03; SSControl = 2'd0;
         for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (memWrite) begin
               wc = k;
               ss = SSout;
               check("latch_ma", memAddr, 32'h80);
            end
         end
         check("latch_wr_cyc", 32'(wc), 32'(LAT + 1));
         check("latch_ss", ss, 32'h1020_7740);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: actual=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
